aes_inv_round_ctrl: RTL
=======================

// Module: aes_inv_round_ctrl
// PURPOSE
//  Sequencer for an iterative (one inverse round per clock) AES decryption datapath. Accepts a cipher key
//  and starts/awaits the external key-schedule unit. Then accepts 128-bit blocks and drives the datapath
//  through AddRoundKey(Nr), Nr-1 full inverse rounds and one final round. Registers the plaintext behind
//  a valid/ready output handshake. Sits between the block stream interface and the inverse-round/key units.
// PARAMETERS
//  Nk  4       key length in 32-bit words (4/6/8)
//  Nr  Nk+6    number of rounds; round index width RW = 4 (covers 0..14)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       synchronous, active-low reset
//  key_in      in   Nk*32   cipher key
//  key_valid   in   1       key offered
//  key_ready   out  1       key can be accepted
//  ke_start    out  1       1-cycle pulse: key-schedule unit starts from ke_key
//  ke_key      out  Nk*32   latched key for the key-schedule unit
//  ke_done     in   1       key-schedule unit finished (round keys 0..Nr stored)
//  data_in     in   128     ciphertext block
//  in_valid    in   1       block offered
//  in_ready    out  1       block can be accepted
//  dp_din      out  128     latched ciphertext to datapath
//  dp_load     out  1       datapath: state <= dp_din ^ rk[rk_addr]
//  dp_round    out  1       datapath: full inverse round with rk[rk_addr]
//  dp_final    out  1       datapath: final round (no InvMixColumns) with rk[rk_addr]
//  rk_addr     out  4       round-key read index
//  dp_next     in   128     datapath combinational next-state value
//  data_out    out  128     plaintext, registered
//  out_valid   out  1       plaintext available
//  out_ready   in   1       consumer accepts plaintext
//  busy        out  1       state is not IDLE/READY
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; key_ready=1; all other outputs 0, incl. ke_key, dp_din, data_out.
//  Also clears the key-loaded flag. Applies from any state, mid-block or mid-expansion; no block is output.
//  States: IDLE, KEXP, READY, LOAD, ROUND, FINAL, HOLD.
//  IDLE: key_ready=1, in_ready=0. key_valid -> ke_key<=key_in, go KEXP.
//  KEXP: ke_start=1 in the first KEXP cycle only; key_ready=in_ready=0. ke_done=1 -> READY.
//   Waits indefinitely; ke_done outside KEXP is ignored.
//  READY: key_ready=1; in_ready=~key_valid (key has priority over a block in the same cycle).
//   key_valid -> ke_key<=key_in, go KEXP (re-key).
//   else in_valid -> dp_din<=data_in, round counter r<=Nr-1, go LOAD.
//  LOAD (1 cycle): dp_load=1, rk_addr=Nr. Next: ROUND; Nr>=10 always.
//  ROUND: dp_round=1, rk_addr=r. r==1 -> FINAL, else r<=r-1.
//  FINAL (1 cycle): dp_final=1, rk_addr=0; data_out<=dp_next at the edge; go HOLD.
//  HOLD: out_valid=1; data_out stable. out_ready=1 -> READY.
//   in_ready=0, key_ready=0 (no back-to-back accept).
//  dp_load/dp_round/dp_final are mutually exclusive, 0 outside their states; rk_addr=0 when none is active.
//  Latency: accept in cycle 0; LOAD cycle 1; ROUND cycles 2..Nr; FINAL cycle Nr+1; out_valid from cycle Nr+2.
//   Nk=4: out_valid in cycle 12.
//  Throughput with out_ready=1: one block per Nr+3 cycles.
//  busy=1 in KEXP, LOAD, ROUND, FINAL, HOLD.
//  in_valid/data_in changes after acceptance do not affect an in-flight block.
//  key_valid during a block is held off: key_ready=0 until READY.
// TESTING (bench models key schedule + inverse round behaviourally)
//  1 Reset: rst_n=0 two cycles -> key_ready=1, in_ready=0, out_valid=0, busy=0, data_out=0.
//  2 key_in=000102030405060708090a0b0c0d0e0f, key_valid 1 cycle -> ke_start single pulse next cycle,
//    ke_key=that key, key_ready=0; stub ke_done 5 cycles later -> READY, in_ready=1.
//  3 data_in=69c4e0d86a7b0430d8cdb78070b4c55a -> rk_addr 10,9..1,0 with load/round x9/final;
//    out_valid in cycle 12; data_out=00112233445566778899aabbccddeeff.
//  4 out_ready=0 for 5 cycles in HOLD -> out_valid, data_out held; in_ready=0; then out_ready=1 -> READY.
//  5 READY with key_valid=in_valid=1 same cycle -> in_ready=0, key accepted, KEXP entered, no LOAD.
//  6 rst_n=0 while rk_addr=6 -> next cycle IDLE, all outputs reset, in_ready=0 until new key;
//    repeat 3 with Nk=8 -> rk_addr 14..0, out_valid in cycle 16.

Source files
------------

// File: rtl/aes_inv_round_ctrl_if.sv
// Signal bundle between the AES inverse-round sequencer and its neighbours:
// key source, key-schedule unit, block source/sink and the inverse-round datapath.
interface aes_inv_round_ctrl_if #(
  parameter int Nk = 4
);
  // Every x_valid/x_ready pair is a strict handshake. A transfer happens on a rising edge
  // where both are 1. Valid may not depend on ready, and payload is held while valid waits.
  logic [Nk*32-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic             ke_start;
  logic [Nk*32-1:0] ke_key;
  logic             ke_done;
  logic [127:0]     data_in;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     dp_din;
  logic             dp_load;
  logic             dp_round;
  logic             dp_final;
  logic [3:0]       rk_addr;
  logic [127:0]     dp_next;
  logic [127:0]     data_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  key_in, key_valid, ke_done, data_in, in_valid, dp_next, out_ready,
    output key_ready, ke_start, ke_key, in_ready, dp_din, dp_load, dp_round, dp_final,
           rk_addr, data_out, out_valid, busy
  );

  modport master (
    output key_in, key_valid, ke_done, data_in, in_valid, dp_next, out_ready,
    input  key_ready, ke_start, ke_key, in_ready, dp_din, dp_load, dp_round, dp_final,
           rk_addr, data_out, out_valid, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for an iterative AES decryption datapath: key hand-off to the key-schedule unit,
// then AddRoundKey(Nr), Nr-1 inverse rounds and a final round per block, output registered.
module aes_inv_round_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_inv_round_ctrl_if.slave       bus,
  output logic [2:0]                state_dbg
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    LOAD  = 3'd3,
    ROUND = 3'd4,
    FINAL = 3'd5,
    HOLD  = 3'd6
  } state_t;

  localparam logic [3:0] NR = 4'(Nr);

  state_t           state_q, state_d;
  logic [3:0]       r_q, r_d;
  logic             ke_first_q;
  logic [Nk*32-1:0] ke_key_q;
  logic [127:0]     din_q;
  logic [127:0]     dout_q;

  logic       take_key, take_blk;
  logic       key_ready, in_ready, ke_start;
  logic       dp_load, dp_round, dp_final;
  logic [3:0] rk_addr;
  logic       out_valid, busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= 4'd0;
      ke_first_q <= 1'b0;
      ke_key_q   <= '0;
      din_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      ke_first_q <= take_key;
      if (take_key) ke_key_q <= bus.key_in;
      if (take_blk) din_q <= bus.data_in;
      if (state_q == FINAL) dout_q <= bus.dp_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    take_key  = 1'b0;
    take_blk  = 1'b0;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    ke_start  = 1'b0;
    dp_load   = 1'b0;
    dp_round  = 1'b0;
    dp_final  = 1'b0;
    rk_addr   = 4'd0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        key_ready = 1'b1;
        if (bus.key_valid) begin
          take_key = 1'b1;
          state_d  = KEXP;
        end
      end
      KEXP: begin
        // ke_first_q marks the cycle right after the key was taken
        ke_start = ke_first_q;
        if (bus.ke_done) state_d = READY;
      end
      READY: begin
        busy      = 1'b0;
        key_ready = 1'b1;
        in_ready  = ~bus.key_valid;
        if (bus.key_valid) begin
          take_key = 1'b1;
          state_d  = KEXP;
        end else if (bus.in_valid) begin
          take_blk = 1'b1;
          r_d      = NR - 4'd1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        dp_load = 1'b1;
        rk_addr = NR;
        state_d = ROUND;
      end
      ROUND: begin
        dp_round = 1'b1;
        rk_addr  = r_q;
        if (r_q == 4'd1) state_d = FINAL;
        else r_d = r_q - 4'd1;
      end
      FINAL: begin
        dp_final = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_ready = key_ready;
  assign bus.in_ready  = in_ready;
  assign bus.ke_start  = ke_start;
  assign bus.ke_key    = ke_key_q;
  assign bus.dp_din    = din_q;
  assign bus.dp_load   = dp_load;
  assign bus.dp_round  = dp_round;
  assign bus.dp_final  = dp_final;
  assign bus.rk_addr   = rk_addr;
  assign bus.data_out  = dout_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign state_dbg     = state_q;
endmodule
